pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register with a valid/ready handshake, synchronous flush with a per-bit bubble mask, and an optional 2-entry skid buffer. It generalises the fixed IF/ID-style stall/flush register so that any stage boundary can use one block: fetch→decode, decode→execute, and so on. It sits between two pipeline stages. Upstream stall becomes `in_ready`=0 and downstream stall becomes `out_ready`=0. A stall-cycle counter is exported for performance monitoring.

## Interface
Parameters:
- `DATA_W`, 64, payload width in bits.
- `CLR_MASK`, {DATA_W{1'b1}}, bits set to 1 are overwritten with `NOP_VALUE` on flush; bits set to 0 keep their value (e.g. PC field).
- `NOP_VALUE`, '0, bubble pattern applied under `CLR_MASK`.
- `CNT_W`, 16, stall counter width.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous kill of all held entries.
- `in_valid`  in  1  upstream beat valid.
- `in_ready`  out  1  block can accept a beat.
- `in_data`  in  DATA_W  upstream payload.
- `out_valid`  out  1  `out_data` holds a live beat.
- `out_ready`  in  1  downstream accepts the beat.
- `out_data`  out  DATA_W  payload to the next stage.
- `stall_cnt`  out  CNT_W  saturating count of stall cycles.

## Operation
- Input transfer: `in_valid & in_ready` at a rising edge. Output transfer: `out_valid & out_ready` at a rising edge.
- Payload is never modified except by flush masking.
- Beats leave in arrival order. No beat is duplicated or dropped, except on flush.
- State machine (skid build): EMPTY, ONE (main entry valid), FULL (main + skid valid).
  - EMPTY: in xfer → ONE; main ← `in_data`.
  - ONE: in & out xfer → ONE; main ← `in_data`.
  - ONE: in xfer only → FULL; skid ← `in_data`.
  - ONE: out xfer only → EMPTY.
  - FULL: out xfer → ONE; main ← skid. No input is accepted in FULL.
- `in_ready` = (state != FULL), driven from a register with no combinational path from `out_ready`.
- `out_valid` = (state != EMPTY). `out_data` = main entry.
- Flush has priority over all other events:
  - next state EMPTY;
  - an input beat presented in the flush cycle is discarded;
  - main entry ← (main & ~`CLR_MASK`) | (`NOP_VALUE` & `CLR_MASK`);
  - an output transfer in the flush cycle is considered completed by the consumer.
- `stall_cnt` increments on every cycle with `out_valid & ~out_ready`, saturates at all-ones, and is not cleared by flush.

## Timing
- Reset values: `out_valid`=0, `out_data`=`NOP_VALUE`, `in_ready`=1 (both builds, once `out_ready` settles), state EMPTY, `stall_cnt`=0.
- Reset asserted mid-operation clears all entries immediately, with no handshake.
- Latency: an input beat accepted at edge N is visible on `out_data` with `out_valid`=1 after edge N, when it lands in main.
- Throughput: 1 beat/cycle when `out_ready`=1 continuously.
- Skid build: after `out_ready` falls, one further beat can be accepted (into FULL). `in_ready` falls in the cycle after that edge.
- Flush at edge N: `out_valid`=0 after edge N. A new beat can be accepted at edge N+1.
- Simultaneous flush with in xfer and/or out xfer: result is EMPTY.

## Configuration
- `PIPE_STAGE_REG_SKID_EN` defined: the 2-entry skid FSM above is built, with registered `in_ready`.
- `PIPE_STAGE_REG_SKID_EN` undefined: single entry (states EMPTY/ONE only).
  - `in_ready` = `out_ready` | ~`out_valid`, combinational.
  - A full entry with `out_ready`=0 back-pressures in the same cycle.
  - Flush, masking, reset and `stall_cnt` behaviour are identical.

## Test plan
Common parameters: `DATA_W`=64, `CLR_MASK`=64'hFFFFFFFF_00000000, `NOP_VALUE`=0.

- Streaming: `out_ready`=1, beats 0x…01..0x…08 on 8 consecutive cycles → same 8 beats in order, each one cycle later, with `stall_cnt`=0.
- Back-pressure (skid): hold `out_ready`=0 for 5 cycles while `in_valid`=1 → exactly 2 beats accepted, `in_ready`=0 afterwards, `stall_cnt`=5. Then release → both beats out in order, no loss.
- Flush bubble: main=64'h8C220004_00400010, pulse flush → `out_valid`=0, `out_data`=64'h00000000_00400010.
- Flush with simultaneous input beat 64'hDEAD_BEEF → beat never appears on output. Next beat accepted one cycle later and delivered normally.
- Async reset asserted mid-FULL, between clock edges → `out_valid`=0 and `out_data`=0 immediately. After release, `in_ready`=1 and `stall_cnt`=0.
- `stall_cnt` saturation with `CNT_W`=4: 20 stall cycles → counter reads 15 and holds.

Source files
------------

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle between a pipe_stage_reg and the stages on either side of it.
// master = the surrounding pipeline that drives the stage, slave = the stage register itself.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, stall_cnt
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, stall_cnt
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, masked flush bubble and saturating stall counter.
// Define PIPE_STAGE_REG_SKID_EN for the 2-entry skid build with registered in_ready.
module pipe_stage_reg #(
    parameter int                DATA_W    = 64,
    parameter logic [DATA_W-1:0] CLR_MASK  = {DATA_W{1'b1}},
    parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
    parameter int                CNT_W     = 16
) (
    input logic             clk,
    input logic             rst,
    pipe_stage_reg_if.slave bus
);
    localparam logic [1:0]       ST_EMPTY = 2'd0;
    localparam logic [1:0]       ST_ONE   = 2'd1;
    localparam logic [1:0]       ST_FULL  = 2'd2;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Flush replaces masked fields with the bubble pattern; unmasked fields (e.g. PC) survive.
    function automatic logic [DATA_W-1:0] f_bubble(input logic [DATA_W-1:0] data);
        f_bubble = (data & ~CLR_MASK) | (NOP_VALUE & CLR_MASK);
    endfunction

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_main;
    logic              r_out_valid;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic [1:0]        w_state_nx;
    logic [DATA_W-1:0] w_main_nx;
    logic [CNT_W-1:0]  w_stall_nx;
    logic              w_in_ready;
    logic              w_in_xfer;
    logic              w_out_xfer;

`ifdef PIPE_STAGE_REG_SKID_EN
    logic [DATA_W-1:0] r_skid;
    logic              r_in_ready;
    logic [DATA_W-1:0] w_skid_nx;

    // in_ready comes from a flop so out_ready never reaches it combinationally.
    assign w_in_ready = r_in_ready;
`else
    assign w_in_ready = bus.out_ready | ~r_out_valid;
`endif

    assign w_in_xfer  = bus.in_valid & w_in_ready;
    assign w_out_xfer = r_out_valid & bus.out_ready;

    // Next-state, next-entry and stall-counter computation.
    always_comb begin
        w_state_nx = r_state;
        w_main_nx  = r_main;
`ifdef PIPE_STAGE_REG_SKID_EN
        w_skid_nx  = r_skid;
`endif
        if (bus.flush) begin
            w_state_nx = ST_EMPTY;
            w_main_nx  = f_bubble(r_main);
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        w_state_nx = ST_ONE;
                        w_main_nx  = bus.in_data;
                    end else begin
                        w_state_nx = ST_EMPTY;
                    end
                end
                ST_ONE: begin
`ifdef PIPE_STAGE_REG_SKID_EN
                    if (w_in_xfer && w_out_xfer) begin
                        w_main_nx = bus.in_data;
                    end else if (w_in_xfer) begin
                        w_state_nx = ST_FULL;
                        w_skid_nx  = bus.in_data;
                    end else if (w_out_xfer) begin
                        w_state_nx = ST_EMPTY;
                    end else begin
                        w_state_nx = ST_ONE;
                    end
`else
                    if (w_in_xfer) begin
                        w_main_nx = bus.in_data;
                    end else if (w_out_xfer) begin
                        w_state_nx = ST_EMPTY;
                    end else begin
                        w_state_nx = ST_ONE;
                    end
`endif
                end
`ifdef PIPE_STAGE_REG_SKID_EN
                ST_FULL: begin
                    if (w_out_xfer) begin
                        w_state_nx = ST_ONE;
                        w_main_nx  = r_skid;
                    end else begin
                        w_state_nx = ST_FULL;
                    end
                end
`endif
                default: begin
                    w_state_nx = ST_EMPTY;
                end
            endcase
        end

        if (r_out_valid && !bus.out_ready && (r_stall_cnt != CNT_MAX)) begin
            w_stall_nx = r_stall_cnt + CNT_ONE;
        end else begin
            w_stall_nx = r_stall_cnt;
        end
    end

    // State, payload and counter registers; reset clears entries without any handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_EMPTY;
            r_main      <= NOP_VALUE;
            r_out_valid <= 1'b0;
            r_stall_cnt <= {CNT_W{1'b0}};
`ifdef PIPE_STAGE_REG_SKID_EN
            r_skid      <= NOP_VALUE;
            r_in_ready  <= 1'b1;
`endif
        end else begin
            r_state     <= w_state_nx;
            r_main      <= w_main_nx;
            r_out_valid <= (w_state_nx != ST_EMPTY);
            r_stall_cnt <= w_stall_nx;
`ifdef PIPE_STAGE_REG_SKID_EN
            r_skid      <= w_skid_nx;
            r_in_ready  <= (w_state_nx != ST_FULL);
`endif
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_main;
    assign bus.stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed table-driven bench for pipe_stage_reg; expectations follow the build selected by PIPE_STAGE_REG_SKID_EN.
module tb_pipe_stage_reg;
`ifdef PIPE_STAGE_REG_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif
    localparam logic [63:0] MASK = 64'hFFFFFFFF_00000000;

    typedef struct {
        string       nm;
        logic        fl;
        logic        iv;
        logic [63:0] d;
        logic        ordy;
        logic        ir;
        logic        ov;
        logic [63:0] od;
        logic [15:0] sc;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    pipe_stage_reg_if #(.DATA_W(64), .CNT_W(16)) bus ();
    pipe_stage_reg_if #(.DATA_W(64), .CNT_W(4))  bus_s ();

    pipe_stage_reg #(.DATA_W(64), .CLR_MASK(MASK), .NOP_VALUE(64'h0), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    pipe_stage_reg #(.DATA_W(64), .CLR_MASK(MASK), .NOP_VALUE(64'h0), .CNT_W(4)) dut_s (
        .clk (clk),
        .rst (rst_n),
        .bus (bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // One clock cycle: drive inputs just after an edge, check in_ready mid-cycle, check outputs after the edge.
    task automatic cyc(input string nm, input logic fl, input logic iv, input logic [63:0] d,
                       input logic ordy, input logic eir, input logic eov,
                       input logic [63:0] eod, input logic [15:0] esc);
        bus.flush     = fl;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        #4;
        chk({nm, ".in_ready"}, {63'h0, bus.in_ready}, {63'h0, eir});
        @(posedge clk);
        #1;
        chk({nm, ".out_valid"}, {63'h0, bus.out_valid}, {63'h0, eov});
        chk({nm, ".out_data"}, bus.out_data, eod);
        chk({nm, ".stall_cnt"}, {48'h0, bus.stall_cnt}, {48'h0, esc});
    endtask

    vec_t tbl[15];
    localparam logic [63:0] BA = 64'hAAAA0000_00000001;
    localparam logic [63:0] BB = 64'hBBBB0000_00000002;
    localparam logic [63:0] BC = 64'hCCCC0000_00000003;

    initial begin
        logic [63:0] sdata;
        // Streaming: one beat per cycle, each visible one edge after acceptance.
        for (int i = 0; i < 8; i++) begin
            sdata = 64'h11110000_00000000 | 64'(i + 1);
            tbl[i] = '{"stream", 1'b0, 1'b1, sdata, 1'b1, 1'b1, 1'b1, sdata, 16'd0};
        end
        tbl[8]  = '{"drain",     1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 64'h11110000_00000008, 16'd0};
        tbl[9]  = '{"load_pc",   1'b0, 1'b1, 64'h8C220004_00400010, 1'b0, 1'b1, 1'b1, 64'h8C220004_00400010, 16'd0};
        tbl[10] = '{"flush",     1'b1, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 64'h00000000_00400010, 16'd0};
        tbl[11] = '{"load2",     1'b0, 1'b1, 64'h12345678_9ABCDEF0, 1'b1, 1'b1, 1'b1, 64'h12345678_9ABCDEF0, 16'd0};
        tbl[12] = '{"flush_in",  1'b1, 1'b1, 64'h00000000_DEADBEEF, 1'b1, 1'b1, 1'b0, 64'h00000000_9ABCDEF0, 16'd0};
        tbl[13] = '{"post_fl",   1'b0, 1'b1, 64'hCAFE0000_00000013, 1'b1, 1'b1, 1'b1, 64'hCAFE0000_00000013, 16'd0};
        tbl[14] = '{"idle",      1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 64'hCAFE0000_00000013, 16'd0};

        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_data = 64'h0; bus.out_ready = 1'b0;
        bus_s.flush = 1'b0; bus_s.in_valid = 1'b0; bus_s.in_data = 64'h0; bus_s.out_ready = 1'b0;

        @(posedge clk);
        #3;
        chk("rst.out_valid", {63'h0, bus.out_valid}, 64'h0);
        chk("rst.out_data", bus.out_data, 64'h0);
        chk("rst.in_ready", {63'h0, bus.in_ready}, 64'h1);
        chk("rst.stall_cnt", {48'h0, bus.stall_cnt}, 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            cyc(tbl[i].nm, tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].ordy,
                tbl[i].ir, tbl[i].ov, tbl[i].od, tbl[i].sc);
        end

        // Back-pressure: one beat held, then 5 stalled cycles with upstream still offering beats.
        cyc("bp_a", 1'b0, 1'b1, BA, 1'b1, 1'b1, 1'b1, BA, 16'd0);
        cyc("bp_s1", 1'b0, 1'b1, BB, 1'b0, SKID, 1'b1, BA, 16'd1);
        for (int k = 2; k <= 5; k++) begin
            cyc("bp_sn", 1'b0, 1'b1, SKID ? BC : BB, 1'b0, 1'b0, 1'b1, BA, 16'(k));
        end
        if (SKID) cyc("bp_r1", 1'b0, 1'b0, BC, 1'b1, 1'b0, 1'b1, BB, 16'd5);
        else      cyc("bp_r1", 1'b0, 1'b1, BB, 1'b1, 1'b1, 1'b1, BB, 16'd5);
        cyc("bp_r2", 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0, BB, 16'd5);

        // Fill (FULL in the skid build), then assert reset between clock edges.
        cyc("rs_a", 1'b0, 1'b1, BA, 1'b0, 1'b1, 1'b1, BA, 16'd5);
        cyc("rs_b", 1'b0, 1'b1, BB, 1'b0, SKID, 1'b1, BA, 16'd6);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.out_valid", {63'h0, bus.out_valid}, 64'h0);
        chk("arst.out_data", bus.out_data, 64'h0);
        chk("arst.stall_cnt", {48'h0, bus.stall_cnt}, 64'h0);
        #2;
        rst_n = 1'b1;
        #1;
        chk("arst.in_ready", {63'h0, bus.in_ready}, 64'h1);
        @(posedge clk);
        #1;
        chk("arst.idle_valid", {63'h0, bus.out_valid}, 64'h0);
        cyc("arst_after", 1'b0, 1'b1, BA, 1'b1, 1'b1, 1'b1, BA, 16'd0);

        // Saturation on the 4-bit counter instance: 20 stalled edges.
        bus_s.in_valid = 1'b1;
        bus_s.in_data  = BC;
        bus_s.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus_s.in_valid = 1'b0;
        chk("sat.load_valid", {63'h0, bus_s.out_valid}, 64'h1);
        chk("sat.start", {60'h0, bus_s.stall_cnt}, 64'h0);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            chk("sat.cnt", {60'h0, bus_s.stall_cnt}, (k > 15) ? 64'd15 : 64'(k));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
